// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
//   Transmit-side FIFO between the DataMem peripheral bus and the UART
//   transmitter. Bytes written by DataMem are queued. They are handed to the
//   UART one at a time, and the UART_STATUS handshake sets the pace, so the
//   CPU can issue back-to-back TX writes without polling.
//
// Parameters
//   DEPTH          FIFO entries (power of two, >= 2)
//   BUSY_TIMEOUT   sysclk cycles to wait for uart_tx_status to fall after a launch
//
// Ports
//   sysclk          in   single clock, all state on rising edge
//   reset           in   asynchronous active-low reset
//   in_txd          in   [7:0] byte from DataMem, stable while in_tx_en is high
//   in_tx_en        in   write strobe from DataMem, asynchronous to sysclk
//   in_tx_status    out  1 = FIFO has space
//   uart_txd        out  [7:0] byte to the UART, held until the next launch
//   uart_tx_en      out  one-cycle launch pulse to the UART
//   uart_tx_status  in   1 = UART idle, 0 = shifting
//   fifo_count      out  occupied entries, 0..DEPTH
//
// Optional feature (macro UART_TXBUF_OVF_FLAG_EN)
//   Adds ovf_flag (out, sticky overflow indication) and ovf_clr (in, clear).
//   Without the macro, bytes written while the FIFO is full are silently lost.
module uart_tx_buffer #(
   parameter int DEPTH        = 8,
   parameter int BUSY_TIMEOUT = 64
) (
   input  logic                   sysclk,
   input  logic                   reset,
   input  logic [7:0]             in_txd,
   input  logic                   in_tx_en,
   output logic                   in_tx_status,
   output logic [7:0]             uart_txd,
   output logic                   uart_tx_en,
   input  logic                   uart_tx_status,
`ifdef UART_TXBUF_OVF_FLAG_EN
   output logic                   ovf_flag,
   input  logic                   ovf_clr,
`endif
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   logic             sync_p0, sync_p1, sync_p2;
   logic             push_vld_p2;
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count, count_nxt;
   logic             full, pop, push_ok;
   state_t           state;
   logic [TMR_W-1:0] timer;

   // ---- stage p0/p1: two-flop synchronizer; p2: previous value for edge detect
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
      end else begin
         sync_p0 <= in_tx_en;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
      end
   end

   // One push per rising edge of the strobe, however long it stays high.
   assign push_vld_p2 = sync_p1 & ~sync_p2;

   // ---- FIFO storage and occupancy
   assign full    = (count == FULL_CNT);
   assign pop     = (state == IDLE) && (count != '0) && uart_tx_status;
   // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
   assign push_ok = push_vld_p2 && (!full || pop);

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (push_ok) mem[wr_ptr] <= in_txd;
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         in_tx_status <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         count        <= count_nxt;
         in_tx_status <= (count_nxt != FULL_CNT);
      end
   end

   assign fifo_count = count;

   // ---- launch FSM: pop and launch happen on the IDLE->LAUNCH edge, so
   // uart_tx_en and uart_txd are valid together while in LAUNCH.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         timer      <= '0;
         uart_tx_en <= 1'b0;
         uart_txd   <= 8'h00;
      end else begin
         uart_tx_en <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  state      <= LAUNCH;
                  uart_tx_en <= 1'b1;
                  uart_txd   <= mem[rd_ptr];
               end
            end
            LAUNCH: begin
               state <= WAIT_BUSY;
               timer <= '0;
            end
            WAIT_BUSY: begin
               // A UART that never reports busy must not stall the queue;
               // the byte is treated as sent.
               if (!uart_tx_status)       state <= WAIT_DONE;
               else if (timer == TMR_LAST) state <= IDLE;
               else                        timer <= timer + TMR_W'(1);
            end
            WAIT_DONE: begin
               if (uart_tx_status) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UART_TXBUF_OVF_FLAG_EN
   // ---- sticky overflow flag; a new drop wins over a simultaneous clear
   logic drop;
   assign drop = push_vld_p2 && full && !pop;

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset)       ovf_flag <= 1'b0;
      else if (drop)    ovf_flag <= 1'b1;
      else if (ovf_clr) ovf_flag <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
`timescale 1ns/1ps
module tb_uart_tx_buffer;

   localparam int DEPTH        = 8;
   localparam int BUSY_TIMEOUT = 64;
   localparam int M_NORMAL     = 0;
   localparam int M_STUCK_BUSY = 1;
   localparam int M_STUCK_IDLE = 2;

   logic       sysclk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_txd = 8'h00;
   logic       in_tx_en = 1'b0;
   logic       in_tx_status;
   logic [7:0] uart_txd;
   logic       uart_tx_en;
   logic       uart_tx_status = 1'b1;
   logic [3:0] fifo_count;
`ifdef UART_TXBUF_OVF_FLAG_EN
   logic       ovf_flag;
   logic       ovf_clr = 1'b0;
`endif

   uart_tx_buffer #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
      .sysclk         (sysclk),
      .reset          (reset),
      .in_txd         (in_txd),
      .in_tx_en       (in_tx_en),
      .in_tx_status   (in_tx_status),
      .uart_txd       (uart_txd),
      .uart_tx_en     (uart_tx_en),
      .uart_tx_status (uart_tx_status),
`ifdef UART_TXBUF_OVF_FLAG_EN
      .ovf_flag       (ovf_flag),
      .ovf_clr        (ovf_clr),
`endif
      .fifo_count     (fifo_count)
   );

   always #5 sysclk = ~sysclk;

   int n_chk = 0;
   int n_fail = 0;
   int edge_cnt = 0;

   always @(posedge sysclk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // UART transmitter stand-in: busy for busy_len cycles after each launch.
   int mode = M_NORMAL;
   int busy_len = 5;
   int busy_left = 0;

   always @(posedge sysclk) begin
      #2;
      if (uart_tx_en) busy_left = busy_len;
      if (mode == M_STUCK_BUSY)      uart_tx_status = 1'b0;
      else if (mode == M_STUCK_IDLE) uart_tx_status = 1'b1;
      else if (busy_left > 0) begin
         uart_tx_status = 1'b0;
         busy_left--;
      end else uart_tx_status = 1'b1;
   end

   // Reference model: a byte queue fed 3 edges after each strobe rise,
   // drained by every observed launch.
   typedef struct { int at_edge; logic [7:0] data; } pend_t;
   pend_t      pend_q[$];
   logic [7:0] mdl_q[$];
   logic [7:0] launch_log[$];
   bit         mdl_on = 1'b0;
   int         n_pulses = 0;
   int         n_accept = 0;
   int         peak = 0;
   int         last_pulse_edge = -1000;
   int         last_gap = 0;
   logic [7:0] last_txd = 8'h00;
   logic       prev_stat = 1'b1;
   logic       prev_en = 1'b0;

   always @(negedge sysclk) begin
      if (!reset) begin
         mdl_q.delete();
         pend_q.delete();
      end else if (mdl_on) begin
         if (uart_tx_en) begin
            n_pulses++;
            check("launch_while_uart_busy", prev_stat, 1'b1);
            last_gap = edge_cnt - last_pulse_edge;
            check("launch_spacing", last_gap >= 3, 1'b1);
            last_pulse_edge = edge_cnt;
            last_txd = uart_txd;
            launch_log.push_back(uart_txd);
            if (mdl_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL launch_from_empty: got launch of %0h expected none", uart_txd);
            end else check("launch_txd", uart_txd, mdl_q.pop_front());
         end
         if (pend_q.size() > 0 && pend_q[0].at_edge == edge_cnt) begin
            pend_t p;
            p = pend_q.pop_front();
            if (mdl_q.size() < DEPTH) begin
               mdl_q.push_back(p.data);
               n_accept++;
            end
         end
         if (in_tx_en && !prev_en) pend_q.push_back('{edge_cnt + 3, in_txd});
         check("fifo_count", fifo_count, mdl_q.size());
         check("in_tx_status", in_tx_status, mdl_q.size() != DEPTH);
         if (mdl_q.size() > peak) peak = mdl_q.size();
      end
      prev_stat = uart_tx_status;
      prev_en   = in_tx_en;
   end

   task automatic write_byte(input logic [7:0] b, input int hold, input int gap);
      @(posedge sysclk);
      #1;
      in_txd   = b;
      in_tx_en = 1'b1;
      repeat (hold) @(posedge sysclk);
      #1 in_tx_en = 1'b0;
      repeat (gap) @(posedge sysclk);
   endtask

   task automatic drain(input int settle);
      int t = 0;
      while ((mdl_q.size() != 0 || pend_q.size() != 0) && t < 20000) begin
         @(posedge sysclk);
         t++;
      end
      check("drain_in_time", t < 20000, 1'b1);
      repeat (settle) @(posedge sysclk);
   endtask

   typedef struct {
      logic [7:0] data;
      int         hold;
      int         mode;
      int         busy;
      logic [7:0] exp_txd;
      int         exp_pulses;
      int         exp_peak;
   } vec_t;

   initial begin
      vec_t vecs[4];
      int   p0, p1, t;

      vecs[0] = '{8'h55, 20, M_NORMAL,     12, 8'h55, 1, 1};
      vecs[1] = '{8'h00,  3, M_NORMAL,      1, 8'h00, 1, 1};
      vecs[2] = '{8'hFF,  7, M_STUCK_IDLE,  0, 8'hFF, 1, 1};
      vecs[3] = '{8'h3C, 50, M_NORMAL,     40, 8'h3C, 1, 1};

      // Reset held with the strobe toggling
      #2 reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge sysclk);
         #1;
         in_tx_en = i[1];
         in_txd   = 8'(i * 7);
         @(negedge sysclk);
         check("rst_uart_tx_en", uart_tx_en, 1'b0);
         check("rst_fifo_count", fifo_count, 0);
         check("rst_in_tx_status", in_tx_status, 1'b1);
         check("rst_uart_txd", uart_txd, 8'h00);
      end
      in_tx_en = 1'b0;
      repeat (3) @(posedge sysclk);
      #1 reset = 1'b1;
      mdl_on = 1'b1;
      repeat (3) @(posedge sysclk);

      // Single-byte vectors
      for (int i = 0; i < 4; i++) begin
         mode     = vecs[i].mode;
         busy_len = vecs[i].busy;
         p0       = n_pulses;
         peak     = 0;
         write_byte(vecs[i].data, vecs[i].hold, 3);
         drain(vecs[i].busy + 80);
         @(negedge sysclk);
         check("vec_pulses", n_pulses - p0, vecs[i].exp_pulses);
         check("vec_txd", last_txd, vecs[i].exp_txd);
         check("vec_peak", peak, vecs[i].exp_peak);
         check("vec_final_count", fifo_count, 0);
      end
      mode = M_NORMAL;

      // Burst while the UART is still busy with an earlier frame
      mode     = M_STUCK_BUSY;
      busy_len = 1000;
      p0       = n_pulses;
      peak     = 0;
      launch_log.delete();
      write_byte(8'hCC, 4, 3);
      write_byte(8'h01, 4, 3);
      write_byte(8'hA5, 4, 3);
      @(negedge sysclk);
      check("burst_count", fifo_count, 3);
      check("burst_no_launch_busy", n_pulses - p0, 0);
      mode = M_NORMAL;
      drain(1100);
      check("burst_pulses", n_pulses - p0, 3);
      check("burst_peak", peak, 3);
      check("burst_log_size", launch_log.size(), 3);
      if (launch_log.size() == 3) begin
         check("burst_order0", launch_log[0], 8'hCC);
         check("burst_order1", launch_log[1], 8'h01);
         check("burst_order2", launch_log[2], 8'hA5);
      end

      // Fill past DEPTH with the UART stuck busy
      mode = M_STUCK_BUSY;
      p0   = n_pulses;
      for (int i = 0; i < 9; i++) write_byte(8'(8'h10 + i), 3, 3);
      @(negedge sysclk);
      check("full_count", fifo_count, 8);
      check("full_in_tx_status", in_tx_status, 1'b0);
      check("full_no_launch", n_pulses - p0, 0);
`ifdef UART_TXBUF_OVF_FLAG_EN
      check("ovf_flag_set", ovf_flag, 1'b1);
      @(posedge sysclk);
      #1 ovf_clr = 1'b1;
      @(posedge sysclk);
      #1 ovf_clr = 1'b0;
      @(negedge sysclk);
      check("ovf_flag_cleared", ovf_flag, 1'b0);
`endif
      mode     = M_NORMAL;
      busy_len = 3;
      drain(90);
      check("full_pulses", n_pulses - p0, 8);
      check("full_last_txd", last_txd, 8'h17);

      // UART never reports busy: timeout, then the next byte goes out
      mode = M_STUCK_IDLE;
      p0   = n_pulses;
      write_byte(8'h5A, 3, 3);
      write_byte(8'hA6, 3, 3);
      t = 0;
      while (n_pulses - p0 < 2 && t < 300) begin
         @(posedge sysclk);
         t++;
      end
      @(negedge sysclk);
      check("timeout_second_launch", n_pulses - p0, 2);
      check("timeout_launch_gap", last_gap, BUSY_TIMEOUT + 2);
      check("timeout_second_txd", last_txd, 8'hA6);
      drain(80);
      mode = M_NORMAL;

      // Reset while a frame is in flight with four bytes queued
      busy_len = 300;
      p0       = n_pulses;
      for (int i = 0; i < 5; i++) write_byte(8'(8'hB0 + i), 3, 3);
      @(negedge sysclk);
      check("midrst_queued", fifo_count, 4);
      check("midrst_one_launch", n_pulses - p0, 1);
      @(posedge sysclk);
      #1 reset = 1'b0;
      repeat (2) @(posedge sysclk);
      @(negedge sysclk);
      check("midrst_count", fifo_count, 0);
      check("midrst_in_tx_status", in_tx_status, 1'b1);
      check("midrst_uart_tx_en", uart_tx_en, 1'b0);
      check("midrst_uart_txd", uart_txd, 8'h00);
      @(posedge sysclk);
      #1 reset = 1'b1;
      p1 = n_pulses;
      repeat (400) @(posedge sysclk);
      @(negedge sysclk);
      check("midrst_no_launch", n_pulses - p1, 0);
      check("midrst_idle_count", fifo_count, 0);
      busy_len = 4;
      write_byte(8'h77, 3, 3);
      drain(80);
      check("midrst_new_launch", n_pulses - p1, 1);
      check("midrst_new_txd", last_txd, 8'h77);

      // Randomized traffic against the queue model
      p0 = n_pulses;
      p1 = n_accept;
      for (int i = 0; i < 40; i++) begin
         busy_len = $urandom_range(1, 30);
         mode     = ($urandom_range(0, 7) == 0) ? M_STUCK_IDLE : M_NORMAL;
         write_byte(8'($urandom), $urandom_range(3, 8), $urandom_range(3, 25));
      end
      mode = M_NORMAL;
      drain(120);
      check("rand_all_launched", n_pulses - p0, n_accept - p1);
      check("rand_final_count", fifo_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
